// File: rtl/maze_wall_query.sv
// Wall-flag responder for the ghost movers: reads the four neighbours of a
// queried tile from the synchronous maze ROM. Optional macro TUNNEL_WRAP_EN.
module maze_wall_query #(
    parameter int GRID_W     = 28,
    parameter int GRID_H     = 31,
    parameter int ADDR_W     = 10,
    parameter int TUNNEL_ROW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_x,
    input  logic [5:0]        req_y,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [5:0]        resp_x,
    output logic [5:0]        resp_y,
    output logic              wall_up,
    output logic              wall_down,
    output logic              wall_left,
    output logic              wall_right,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data
);

    typedef enum logic [2:0] {IDLE, RD_U, RD_D, RD_L, RD_R, CAP, RESP} state_t;

    localparam logic signed [6:0] GW_S = 7'(GRID_W);
    localparam logic signed [6:0] GH_S = 7'(GRID_H);

    state_t            state_q, state_d;
    logic [5:0]        x_q, x_d, y_q, y_d;
    logic              rd_ok_q, rd_ok_d;
    logic              up_s_q, up_s_d, dn_s_q, dn_s_d, lf_s_q, lf_s_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [5:0]        resp_x_q, resp_x_d, resp_y_q, resp_y_d;
    logic              wall_up_q, wall_up_d, wall_down_q, wall_down_d;
    logic              wall_left_q, wall_left_d, wall_right_q, wall_right_d;
    logic              rom_en_q, rom_en_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic [5:0]        x_src, y_src;
    logic signed [6:0] xs, ys, ny_u, ny_d, nx_l, nx_r, lf_x, rt_x;
    logic              q_oob, up_ok, dn_ok, lf_ok, rt_ok, cap_bit;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [6:0] tx, input logic [6:0] ty);
        return ADDR_W'(ty) * ADDR_W'(GRID_W) + ADDR_W'(tx);
    endfunction

    // Neighbours are derived from the incoming request while idle so the
    // first ROM address is ready in the very first read state.
    always_comb begin
        x_src = (state_q == IDLE) ? req_x : x_q;
        y_src = (state_q == IDLE) ? req_y : y_q;
        xs    = $signed({1'b0, x_src});
        ys    = $signed({1'b0, y_src});
        ny_u  = ys - 7'sd1;
        ny_d  = ys + 7'sd1;
        nx_l  = xs - 7'sd1;
        nx_r  = xs + 7'sd1;
        q_oob = (xs >= GW_S) || (ys >= GH_S);
        up_ok = !q_oob && (ny_u >= 7'sd0);
        dn_ok = !q_oob && (ny_d < GH_S);
        lf_x  = nx_l;
        rt_x  = nx_r;
        lf_ok = !q_oob && (nx_l >= 7'sd0);
        rt_ok = !q_oob && (nx_r < GW_S);
`ifdef TUNNEL_WRAP_EN
        if (y_src == 6'(TUNNEL_ROW)) begin
            if (nx_l < 7'sd0) begin
                lf_x  = GW_S - 7'sd1;
                lf_ok = !q_oob;
            end
            if (nx_r >= GW_S) begin
                rt_x  = 7'sd0;
                rt_ok = !q_oob;
            end
        end
`endif
        // A skipped read returns a forced wall instead of stale ROM data.
        cap_bit = rd_ok_q ? rom_data : 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        rd_ok_d      = rom_en_q;
        up_s_d       = up_s_q;
        dn_s_d       = dn_s_q;
        lf_s_d       = lf_s_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_x_d     = resp_x_q;
        resp_y_d     = resp_y_q;
        wall_up_d    = wall_up_q;
        wall_down_d  = wall_down_q;
        wall_left_d  = wall_left_q;
        wall_right_d = wall_right_q;
        rom_en_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = RD_U;
                    x_d         = req_x;
                    y_d         = req_y;
                    req_ready_d = 1'b0;
                    rom_en_d    = up_ok;
                    if (up_ok) rom_addr_d = tile_addr(xs, ny_u);
                end
            end
            RD_U: begin
                state_d  = RD_D;
                rom_en_d = dn_ok;
                if (dn_ok) rom_addr_d = tile_addr(xs, ny_d);
            end
            RD_D: begin
                state_d  = RD_L;
                up_s_d   = cap_bit;
                rom_en_d = lf_ok;
                if (lf_ok) rom_addr_d = tile_addr(lf_x, ys);
            end
            RD_L: begin
                state_d  = RD_R;
                dn_s_d   = cap_bit;
                rom_en_d = rt_ok;
                if (rt_ok) rom_addr_d = tile_addr(rt_x, ys);
            end
            RD_R: begin
                state_d = CAP;
                lf_s_d  = cap_bit;
            end
            CAP: begin
                state_d      = RESP;
                wall_up_d    = up_s_q;
                wall_down_d  = dn_s_q;
                wall_left_d  = lf_s_q;
                wall_right_d = cap_bit;
                resp_x_d     = x_q;
                resp_y_d     = y_q;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            rd_ok_q      <= 1'b0;
            up_s_q       <= 1'b0;
            dn_s_q       <= 1'b0;
            lf_s_q       <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_x_q     <= '0;
            resp_y_q     <= '0;
            wall_up_q    <= 1'b0;
            wall_down_q  <= 1'b0;
            wall_left_q  <= 1'b0;
            wall_right_q <= 1'b0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rd_ok_q      <= rd_ok_d;
            up_s_q       <= up_s_d;
            dn_s_q       <= dn_s_d;
            lf_s_q       <= lf_s_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_x_q     <= resp_x_d;
            resp_y_q     <= resp_y_d;
            wall_up_q    <= wall_up_d;
            wall_down_q  <= wall_down_d;
            wall_left_q  <= wall_left_d;
            wall_right_q <= wall_right_d;
            rom_en_q     <= rom_en_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_x     = resp_x_q;
    assign resp_y     = resp_y_q;
    assign wall_up    = wall_up_q;
    assign wall_down  = wall_down_q;
    assign wall_left  = wall_left_q;
    assign wall_right = wall_right_q;
    assign rom_en     = rom_en_q;
    assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_maze_wall_query.sv
// Bench for maze_wall_query: spec-level wall model plus directed queries.
module tb_maze_wall_query;

    localparam int GW = 28;
    localparam int GH = 31;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, resp_valid, resp_ready;
    logic [5:0] req_x, req_y, resp_x, resp_y;
    logic       wall_up, wall_down, wall_left, wall_right;
    logic       rom_en, rom_data;
    logic [9:0] rom_addr;

    maze_wall_query dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_x(resp_x), .resp_y(resp_y),
        .wall_up(wall_up), .wall_down(wall_down),
        .wall_left(wall_left), .wall_right(wall_right),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    bit mem [0:1023];
    int tests = 0;
    int fails = 0;
    int rom_log [$];

    always @(posedge clk or posedge reset)
        if (reset) rom_data <= 1'b0;
        else if (rom_en) rom_data <= mem[rom_addr];

    always @(negedge clk) if (!reset && rom_en) rom_log.push_back(int'(rom_addr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit tile(input int x, input int y);
        if (x < 0 || y < 0 || x >= GW || y >= GH) return 1'b1;
        return mem[y*GW + x];
    endfunction

    // {up, down, left, right}
    function automatic logic [3:0] exp_walls(input int x, input int y);
        bit l, r;
        if (x >= GW || y >= GH) return 4'hF;
        l = tile(x-1, y);
        r = tile(x+1, y);
`ifdef TUNNEL_WRAP_EN
        if (y == 14) begin
            l = tile((x + GW - 1) % GW, y);
            r = tile((x + 1) % GW, y);
        end
`endif
        return {tile(x, y-1), tile(x, y+1), l, r};
    endfunction

    // Transaction-level model: idle / busy for five edges / responding.
    int         m_ph, m_cnt, m_lx, m_ly;
    logic       m_rv;
    logic [3:0] m_w;
    logic [5:0] m_rx, m_ry;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph <= 0; m_cnt <= 0; m_rv <= 1'b0; m_w <= 4'h0; m_rx <= '0; m_ry <= '0;
        end else begin
            case (m_ph)
                0: if (req_valid) begin
                    m_lx <= int'(req_x); m_ly <= int'(req_y); m_cnt <= 0; m_ph <= 1;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == 4) begin
                        m_ph <= 2; m_rv <= 1'b1; m_w <= exp_walls(m_lx, m_ly);
                        m_rx <= 6'(m_lx); m_ry <= 6'(m_ly);
                    end
                end
                default: if (resp_ready) begin m_rv <= 1'b0; m_ph <= 0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("req_ready", req_ready, m_ph == 0);
            chk("resp_valid", resp_valid, m_rv);
            chk("resp_x", resp_x, m_rx);
            chk("resp_y", resp_y, m_ry);
            chk("walls", {wall_up, wall_down, wall_left, wall_right}, m_w);
            if (m_ph != 1) chk("rom_en_quiet", rom_en, 1'b0);
        end
    end

    task automatic chk_reset_vals();
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_xy", {resp_x, resp_y}, 12'h0);
        chk("rst_walls", {wall_up, wall_down, wall_left, wall_right}, 4'h0);
        chk("rst_rom_en", rom_en, 1'b0);
        chk("rst_rom_addr", rom_addr, 10'd0);
    endtask

    task automatic query(input int x, input int y, output int lat);
        rom_log.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = 6'(x); req_y = 6'(y);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin lat = i; break; end
        end
        chk("latency", lat, 5);
    endtask

    task automatic finish_resp(input int hold);
        repeat (hold) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; resp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
        #2 chk_reset_vals();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: interior tile
        mem[117] = 1'b1; mem[173] = 1'b0; mem[144] = 1'b1; mem[146] = 1'b0;
        query(5, 5, lat);
        chk("t1_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b1010);
        chk("t1_resp", {resp_x, resp_y}, {6'd5, 6'd5});
        chk("t1_nreads", rom_log.size(), 4);
        if (rom_log.size() == 4) begin
            chk("t1_a0", rom_log[0], 117); chk("t1_a1", rom_log[1], 173);
            chk("t1_a2", rom_log[2], 144); chk("t1_a3", rom_log[3], 146);
        end
        finish_resp(0);

        // 2: corner on an all-zero ROM
        for (int i = 0; i < 1024; i++) mem[i] = 1'b0;
        query(0, 0, lat);
        chk("t2_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b1010);
        chk("t2_nreads", rom_log.size(), 2);
        if (rom_log.size() == 2) begin
            chk("t2_a0", rom_log[0], 28); chk("t2_a1", rom_log[1], 1);
        end
        finish_resp(0);

        // 3: out-of-range query
        query(30, 3, lat);
        chk("t3_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b1111);
        chk("t3_nreads", rom_log.size(), 0);
        chk("t3_resp", {resp_x, resp_y}, {6'd30, 6'd3});
        finish_resp(0);

        // 4: back-pressure
        mem[30] = 1'b1; mem[59] = 1'b1;
        query(2, 2, lat);
        chk("t4_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b1001);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", resp_valid, 1'b1);
            chk("t4_hold_ready", req_ready, 1'b0);
            chk("t4_hold_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b1001);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("t4_drop_valid", resp_valid, 1'b0);
        chk("t4_req_ready", req_ready, 1'b1);
        chk("t4_walls_kept", {wall_up, wall_down, wall_left, wall_right}, 4'b1001);

        // 5: reset during the left read
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = 6'd3; req_y = 6'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1 chk_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("t5_no_resp", resp_valid, 1'b0);
        end
        query(1, 1, lat);
        chk("t5_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b0001);
        chk("t5_resp", {resp_x, resp_y}, {6'd1, 6'd1});
        finish_resp(2);

        // 6: tunnel row
        mem[419] = 1'b0; mem[393] = 1'b1;
        query(0, 14, lat);
`ifdef TUNNEL_WRAP_EN
        chk("t6_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b0001);
        chk("t6_read419", (rom_log.size() > 2) ? rom_log[2] : -1, 419);
`else
        chk("t6_walls", {wall_up, wall_down, wall_left, wall_right}, 4'b0011);
        chk("t6_nreads", rom_log.size(), 3);
`endif
        finish_resp(0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
